// File: rtl/aes_pkg.sv
// Shared AES-256 constants and round helper functions for the iterative cipher core.
package aes_pkg;

  localparam logic [3:0] NR = 4'd14;

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column word holds row 0 in its top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box; the table is stored byte 0 first at the MSB end.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x), which is {~x, 3'b000}.
  assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-256 encryption core: one round per clock with the key schedule expanded on the fly.
module aes_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [127:0] datain,
  output logic         busy,
  output logic         done,
  output logic [127:0] dataout
);

  logic [127:0] state_q, state_d, ka_q, ka_d, kb_q, kb_d, dataout_q, dataout_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [127:0] sub_s, shift_s, mix_s, rk_s;
  logic [31:0]  sw_in_s, sw_out_s, t_s, w0_s, w1_s, w2_s, w3_s;

  for (genvar i = 0; i < 16; i++) begin : g_subbytes
    aes_sbox u_sbox (.in_byte(state_q[8*i +: 8]), .out_byte(sub_s[8*i +: 8]));
  end

  for (genvar j = 0; j < 4; j++) begin : g_subword
    aes_sbox u_sbox (.in_byte(sw_in_s[8*j +: 8]), .out_byte(sw_out_s[8*j +: 8]));
  end

  assign shift_s = shift_rows(sub_s);
  assign mix_s   = {mix_column(shift_s[127:96]), mix_column(shift_s[95:64]),
                    mix_column(shift_s[63:32]),  mix_column(shift_s[31:0])};

  // Next round key: even rounds rotate and add Rcon, odd rounds only substitute.
  always_comb begin
    sw_in_s = kb_q[31:0];
    t_s     = sw_out_s;
    if (!round_q[0]) begin
      sw_in_s = {kb_q[23:0], kb_q[31:24]};
      t_s     = sw_out_s ^ {rcon(round_q[3:1]), 24'h000000};
    end else begin
      sw_in_s = kb_q[31:0];
      t_s     = sw_out_s;
    end
    w0_s = ka_q[127:96] ^ t_s;
    w1_s = ka_q[95:64]  ^ w0_s;
    w2_s = ka_q[63:32]  ^ w1_s;
    w3_s = ka_q[31:0]   ^ w2_s;
    if (round_q == 4'd1) begin
      rk_s = kb_q;
    end else begin
      rk_s = {w0_s, w1_s, w2_s, w3_s};
    end
  end

  // Control and datapath next-state: load on start, otherwise advance one round.
  always_comb begin
    state_d   = state_q;
    ka_d      = ka_q;
    kb_d      = kb_q;
    round_d   = round_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dataout_d = dataout_q;
    if (!busy_q) begin
      if (start) begin
        state_d = datain ^ key[255:128];
        ka_d    = key[255:128];
        kb_d    = key[127:0];
        round_d = 4'd1;
        busy_d  = 1'b1;
      end else begin
        round_d = round_q;
      end
    end else begin
      if (round_q == NR) begin
        state_d   = shift_s ^ rk_s;
        dataout_d = shift_s ^ rk_s;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        round_d   = 4'd0;
      end else begin
        state_d = mix_s ^ rk_s;
        round_d = round_q + 4'd1;
      end
      if (round_q != 4'd1) begin
        ka_d = kb_q;
        kb_d = rk_s;
      end else begin
        kb_d = kb_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= 128'h0;
      ka_q      <= 128'h0;
      kb_q      <= 128'h0;
      round_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dataout_q <= 128'h0;
    end else begin
      state_q   <= state_d;
      ka_q      <= ka_d;
      kb_q      <= kb_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dataout_q <= dataout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataout = dataout_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Bench for aes_cipher: known FIPS-197 vectors plus random blocks checked against a byte-level AES-256 model.
module tb_aes_cipher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key = 256'h0;
  logic [127:0] datain = 128'h0;
  logic         busy, done;
  logic [127:0] dataout;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;

  aes_cipher dut (.clk(clk), .rst_n(rst_n), .start(start), .key(key), .datain(datain),
                  .busy(busy), .done(done), .dataout(dataout));

  always #5 clk = ~clk;

  // Reference model: S-box derived from GF(2^8) inversion plus the affine map.
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   u [4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] ct;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = sbox_m[s[row+4*((c+row)%4)]];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) u[row] = t[row+4*c];
          for (int row = 0; row < 4; row++)
            t[row+4*c] = gmul(u[row], 8'h02) ^ gmul(u[(row+1)%4], 8'h03) ^ u[(row+2)%4] ^ u[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Caller sits on a negedge; the following posedge is the start edge.
  task automatic do_start(input logic [255:0] k, input logic [127:0] p);
    key = k;
    datain = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of clocks after the start edge at which done was seen, or -1.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (dataout !== 128'h0) $display("FAIL reset_dataout got=%h exp=0", dataout); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_c3();
    int n;
    do_start(C3_KEY, C3_PT);
    n_checks++; if (busy !== 1'b1) $display("FAIL c3_busy got=%b exp=1", busy); else n_pass++;
    wait_done(n);
    n_checks++; if (n !== 14) $display("FAIL c3_latency got=%0d exp=14", n); else n_pass++;
    n_checks++; if (dataout !== C3_CT) $display("FAIL c3_dataout got=%h exp=%h", dataout, C3_CT); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL c3_busy_at_done got=%b exp=0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL c3_done_pulse got=%b exp=0", done); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (dataout !== C3_CT) $display("FAIL c3_hold got=%h exp=%h", dataout, C3_CT); else n_pass++;
  endtask

  task automatic test_zero();
    int n;
    do_start(256'h0, 128'h0);
    wait_done(n);
    n_checks++; if (n !== 14) $display("FAIL zero_latency got=%0d exp=14", n); else n_pass++;
    n_checks++; if (dataout !== Z_CT) $display("FAIL zero_dataout got=%h exp=%h", dataout, Z_CT); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(256'h0, 128'h0);
    wait_done(n);
    do_start(C3_KEY, C3_PT);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", busy); else n_pass++;
    wait_done(n);
    n_checks++; if (n !== 14) $display("FAIL b2b_latency got=%0d exp=14", n); else n_pass++;
    n_checks++; if (dataout !== C3_CT) $display("FAIL b2b_dataout got=%h exp=%h", dataout, C3_CT); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int n;
    do_start(C3_KEY, C3_PT);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4) begin
        start = 1'b1;
        datain = rand256()[127:0];
      end else if (i == 5) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    n_checks++; if (n !== 14) $display("FAIL ignore_latency got=%0d exp=14", n); else n_pass++;
    n_checks++; if (dataout !== C3_CT) $display("FAIL ignore_dataout got=%h exp=%h", dataout, C3_CT); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, seen;
    logic [255:0] k;
    logic [127:0] p;
    do_start(C3_KEY, C3_PT);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (dataout !== 128'h0) $display("FAIL rstmid_dataout got=%h exp=0", dataout); else n_pass++;
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", seen); else n_pass++;
    k = rand256();
    p = rand256()[127:0];
    do_start(k, p);
    wait_done(n);
    n_checks++; if (dataout !== ref_encrypt(k, p)) $display("FAIL rstmid_restart got=%h exp=%h", dataout, ref_encrypt(k, p)); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_hold_off();
    int n;
    logic [255:0] k;
    logic [127:0] p, exp_ct;
    for (int it = 0; it < 6; it++) begin
      k = rand256();
      p = rand256()[127:0];
      exp_ct = ref_encrypt(k, p);
      do_start(k, p);
      key = rand256();
      datain = rand256()[127:0];
      wait_done(n);
      n_checks++; if (n !== 14) $display("FAIL holdoff_latency it=%0d got=%0d exp=14", it, n); else n_pass++;
      n_checks++; if (dataout !== exp_ct) $display("FAIL holdoff_dataout it=%0d got=%h exp=%h", it, dataout, exp_ct); else n_pass++;
      if (it % 2 == 0) @(negedge clk);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_c3();
    test_zero();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_hold_off();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
